// File: rtl/pixel_window_builder_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_window_builder_if
// Brief    : Pixel stream in / 3x3 window stream out bundle for the window builder.
// Revision : 1.0
// ============================================================================
interface pixel_window_builder_if;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic        sof;
    logic [71:0] window_out;
    logic        window_out_valid;
    logic        frame_done;

    modport master (
        output pixel_in, pixel_in_valid, sof,
        input  window_out, window_out_valid, frame_done
    );

    modport slave (
        input  pixel_in, pixel_in_valid, sof,
        output window_out, window_out_valid, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/pixel_window_builder.sv
`default_nettype none
// ============================================================================
// Module   : pixel_window_builder
// Brief    : Raster pixel stream to 3x3 interior windows using two row buffers.
// Revision : 1.0
// ============================================================================
module pixel_window_builder #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  wire logic               clk,
    input  wire logic               rst,
    pixel_window_builder_if.slave   bus
);
    localparam int c_col_w = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_row_w = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);

    logic [7:0] lb0_mem [0:IMG_WIDTH-1];
    logic [7:0] lb1_mem [0:IMG_WIDTH-1];

    logic [c_col_w-1:0] col_cnt_q, col_cnt_d, cur_col;
    logic [c_row_w-1:0] row_cnt_q, row_cnt_d, cur_row;
    logic [23:0]        col_l_q, col_l_d, col_m_q, col_m_d, new_col;
    logic [71:0]        window_q, window_d;
    logic               window_valid_q, window_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [7:0]         lb0_rd, lb1_rd;
    logic [23:0]        win_cols [0:2];

    always_comb begin
        // sof overrides the counters so the current pixel lands at (0,0)
        cur_col = bus.sof ? '0 : col_cnt_q;
        cur_row = bus.sof ? '0 : row_cnt_q;
        lb0_rd  = lb0_mem[cur_col];
        lb1_rd  = lb1_mem[cur_col];
        // byte r of a column holds row r, top (oldest) first
        new_col = {bus.pixel_in, lb1_rd, lb0_rd};

        win_cols[0] = col_l_q;
        win_cols[1] = col_m_q;
        win_cols[2] = new_col;

        col_cnt_d      = col_cnt_q;
        row_cnt_d      = row_cnt_q;
        col_l_d        = col_l_q;
        col_m_d        = col_m_q;
        window_d       = window_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;

        if (bus.pixel_in_valid) begin
            if (cur_col == c_col_last) begin
                col_cnt_d = '0;
                row_cnt_d = (cur_row == c_row_last) ? '0 : cur_row + 1'b1;
            end else begin
                col_cnt_d = cur_col + 1'b1;
                row_cnt_d = cur_row;
            end
            col_l_d = col_m_q;
            col_m_d = new_col;

            if (cur_row >= c_row_w'(2) && cur_col >= c_col_w'(2)) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        window_d[(3*r+c)*8 +: 8] = win_cols[c][r*8 +: 8];
                    end
                end
                window_valid_d = 1'b1;
                frame_done_d   = (cur_row == c_row_last) && (cur_col == c_col_last);
            end
        end
    end

    // Row buffers are left unreset; emission is gated until two rows exist.
    always_ff @(posedge clk) begin
        if (bus.pixel_in_valid) begin
            lb0_mem[cur_col] <= lb1_rd;
            lb1_mem[cur_col] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q      <= '0;
            row_cnt_q      <= '0;
            col_l_q        <= '0;
            col_m_q        <= '0;
            window_q       <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            col_cnt_q      <= col_cnt_d;
            row_cnt_q      <= row_cnt_d;
            col_l_q        <= col_l_d;
            col_m_q        <= col_m_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.window_out       = window_q;
    assign bus.window_out_valid = window_valid_q;
    assign bus.frame_done       = frame_done_q;
endmodule
`default_nettype wire

// File: doc/pixel_window_builder.md
# pixel_window_builder

Raster-to-window front end for the edge-detection datapath. It accepts one 8-bit grayscale pixel per valid cycle in raster order and keeps two full-row line buffers. It emits the 3x3 neighbourhood of every interior pixel as a packed 72-bit word with a valid strobe. It sits directly upstream of the gradient stage and drives that stage's 72-bit window input and window-valid input.

## Interface
- IMG_WIDTH, default 256: pixels per row; legal range 3..1024.
- IMG_HEIGHT, default 256: rows per frame; legal range 3..1024.
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- pixel_in  in  8: unsigned grayscale pixel.
- pixel_in_valid  in  1: pixel_in is accepted this cycle. There is no backpressure; every valid pixel is consumed.
- sof  in  1: start of frame. Sampled only when pixel_in_valid=1; marks that pixel as (row 0, col 0).
- window_out  out  72: 3x3 window. Byte i = window_out[i*8+:8], with i = 3*r + c. r=0 is the top (oldest) row, c=0 is the left (oldest) column.
- window_out_valid  out  1: window_out holds a new window this cycle (one-cycle pulse per window).
- frame_done  out  1: one-cycle pulse, coincident with the window_out_valid of the last window of a frame.

## Operation
- Reset: clock and reset behaviour is fixed as one clock with asynchronous, active-high reset.
  - rst clears col_cnt, row_cnt, window registers, window_out, window_out_valid and frame_done to 0.
  - Line-buffer contents are not reset. Stale data is never emitted because output is gated by row >= 2.
- Counters:
  - col_cnt runs 0..IMG_WIDTH-1 and row_cnt runs 0..IMG_HEIGHT-1. Both advance only on accepted pixels.
  - When col wraps, row increments.
  - After pixel (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0, so the next pixel starts a new frame without needing sof.
- sof with pixel_in_valid: the current pixel is forced to position (0,0) regardless of counter state; counters then continue from (0,1).
  - sof without pixel_in_valid is ignored.
- Line buffers:
  - LB1 holds row r-1 and LB0 holds row r-2, each IMG_WIDTH x 8 bits, addressed by col_cnt.
  - On an accepted pixel at column c:
    - read LB0[c] and LB1[c];
    - write LB0[c] <= LB1[c] and LB1[c] <= pixel_in;
    - shift the three column registers left and load the new right column {LB0[c], LB1[c], pixel_in} for rows top, middle, bottom.
- Emission:
  - The accepted pixel p(r,c) completes a window when r >= 2 and c >= 2.
  - That window is p(r-2..r, c-2..c), with byte 0 = p(r-2,c-2) and byte 8 = p(r,c).
  - No border padding is applied. A frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- Cycles with pixel_in_valid=0: no state changes; window_out holds its last value and window_out_valid=0.
- Stale columns left over from the previous row after a column wrap are never emitted, because c < 2 suppresses output.

## Timing
- Latency is 1 cycle. Pixel p(r,c) accepted at edge N produces window_out and window_out_valid registered at edge N+1.
- Sustained throughput is one window per clock for contiguous interior pixels.
- frame_done is asserted in the same cycle as window_out_valid for p(IMG_HEIGHT-1, IMG_WIDTH-1), and is 0 otherwise.
- Reset asserted mid-frame:
  - outputs go to 0 asynchronously, including any in-flight window_out_valid;
  - the first accepted pixel after deassertion is (0,0).
- rst deassertion must be synchronized to clk externally; this block performs no internal synchronization.
- Single-port line-buffer RAMs are acceptable: the read and write of the same address happen in the same accepted cycle, using read-before-write semantics.

## Test plan
- Reset mid-frame:
  - stimulus: assert rst after 7 pixels of a 4x4 frame, release, send a full 4x4 ramp;
  - required: outputs are 0 during rst, and exactly 4 windows are emitted from the new frame.
- 4x4 ramp, IMG_WIDTH=IMG_HEIGHT=4, pixel = 16*r + c, contiguous:
  - required: 4 windows, each 1 cycle after pixels (2,2), (2,3), (3,2), (3,3);
  - first window bytes 0..8 = 00,01,02,10,11,12,20,21,22;
  - last window bytes = 11,12,13,21,22,23,31,32,33, with frame_done=1 on that cycle only.
- Random valid bubbles (about 40% idle), same 4x4 ramp:
  - required: identical window contents and order;
  - valid appears exactly 1 cycle after each completing pixel, and window_out holds during bubbles.
- Back-to-back frames, no sof: frame 1 is the ramp, frame 2 is the ramp + 0x80.
  - required: 8 windows total, and no window contains bytes from both frames;
  - the fifth window starts with byte 0 = 0x80.
- sof resync: 5 pixels of junk, then sof with the ramp's (0,0):
  - required: windows match the clean-ramp case exactly, with the first window following pixel (2,2) of the resynced stream.
- Default parameters, 256x256 frame of pseudo-random pixels:
  - required: exactly 64516 windows, with contents matching a software 3x3 extraction model;
  - frame_done pulses once, coincident with the window from pixel (255,255).
